// File: rtl/cic_decim_mc_if.sv
// Sample/control bundle between the DDC front end and the multi-channel CIC decimator.
// The master drives samples and rate control; the slave returns decimated words and the active rate.
interface cic_decim_mc_if #(
  parameter int DATAIN_WIDTH  = 16,
  parameter int DATAOUT_WIDTH = 16,
  parameter int MAXRATE       = 1024,
  parameter int NUM_CHANNELS  = 2
);
  localparam int RW = $clog2(MAXRATE + 1);

  logic                                    en_i;
  logic                                    act_i;
  logic [NUM_CHANNELS*DATAIN_WIDTH-1:0]    data_i;
  logic [RW-1:0]                           rate_i;
  logic                                    rate_load_i;
  logic [NUM_CHANNELS*DATAOUT_WIDTH-1:0]   data_o;
  logic                                    val_o;
  logic [RW-1:0]                           rate_o;

  modport master (
    output en_i, act_i, data_i, rate_i, rate_load_i,
    input  data_o, val_o, rate_o
  );

  modport slave (
    input  en_i, act_i, data_i, rate_i, rate_load_i,
    output data_o, val_o, rate_o
  );
endinterface

// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator with its own phase counter; output NUM_STAGES+1 cycles after the strobe-firing accept.
// No backpressure: every act_i beat with en_i=1 is consumed, en_i=0 freezes all state and masks val_o.
module cic_decim_mc #(
  parameter int DATAIN_WIDTH  = 16,
  parameter int DATAOUT_WIDTH = 16,
  parameter int NUM_STAGES    = 3,
  parameter int DIFF_DELAY    = 1,
  parameter int MAXRATE       = 1024,
  parameter int NUM_CHANNELS  = 2
) (
  input logic           clk_i,
  input logic           rst_n_i,
  cic_decim_mc_if.slave bus
);
  localparam int ACC_WIDTH = DATAIN_WIDTH + NUM_STAGES * $clog2(MAXRATE * DIFF_DELAY);
  localparam int RW        = $clog2(MAXRATE + 1);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Assert immediately, release on a clock edge so no flop sees a runt reset removal.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic          en;
  logic          accept;
  logic          load;
  logic          dec_stb;
  logic [RW-1:0] rate_q;
  logic [RW-1:0] phase_q;
  logic [RW-1:0] rate_clamp;
  logic [RW-1:0] eff_rate;
  logic [RW-1:0] eff_phase;

  assign en     = bus.en_i;
  assign accept = en & bus.act_i;
  assign load   = en & bus.rate_load_i;

  always_comb begin
    rate_clamp = bus.rate_i;
    if (bus.rate_i == '0)                 rate_clamp = RW'(1);
    else if (bus.rate_i > RW'(MAXRATE))   rate_clamp = RW'(MAXRATE);
  end

  // A load restarts the phase, so a coinciding accept is phase 0 of the new rate.
  assign eff_rate  = load ? rate_clamp : rate_q;
  assign eff_phase = load ? '0 : phase_q;
  assign dec_stb   = accept && (eff_phase == eff_rate - RW'(1));

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rate_q  <= RW'(MAXRATE);
      phase_q <= '0;
    end else if (en) begin
      rate_q <= eff_rate;
      if (accept) phase_q <= dec_stb ? '0 : eff_phase + RW'(1);
      else        phase_q <= eff_phase;
    end
  end

  logic [ACC_WIDTH-1:0] integ_q [NUM_CHANNELS][NUM_STAGES];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        for (int s = 0; s < NUM_STAGES; s++)
          integ_q[c][s] <= '0;
    end else if (accept) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        integ_q[c][0] <= integ_q[c][0]
                       + ACC_WIDTH'($signed(bus.data_i[c*DATAIN_WIDTH +: DATAIN_WIDTH]));
        for (int s = 1; s < NUM_STAGES; s++)
          integ_q[c][s] <= integ_q[c][s] + integ_q[c][s-1];
      end
    end
  end

  // Slot 0 holds the decimated integrator sample, slots 1..NUM_STAGES the comb results.
  logic [NUM_STAGES:0]  vld_q;
  logic [ACC_WIDTH-1:0] stg_q [NUM_CHANNELS][NUM_STAGES+1];
  logic [ACC_WIDTH-1:0] dly_q [NUM_CHANNELS][NUM_STAGES][DIFF_DELAY];
  logic [NUM_CHANNELS*DATAOUT_WIDTH-1:0] data_q;
  logic                                  val_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      val_q  <= 1'b0;
      data_q <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int s = 0; s <= NUM_STAGES; s++)
          stg_q[c][s] <= '0;
        for (int s = 0; s < NUM_STAGES; s++)
          for (int d = 0; d < DIFF_DELAY; d++)
            dly_q[c][s][d] <= '0;
      end
    end else if (en) begin
      vld_q <= {vld_q[NUM_STAGES-1:0], dec_stb};
      val_q <= vld_q[NUM_STAGES];
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (dec_stb) stg_q[c][0] <= integ_q[c][NUM_STAGES-1];
        // Delay lines step per decimated sample, not per clock.
        for (int s = 0; s < NUM_STAGES; s++) begin
          if (vld_q[s]) begin
            stg_q[c][s+1]  <= stg_q[c][s] - dly_q[c][s][DIFF_DELAY-1];
            dly_q[c][s][0] <= stg_q[c][s];
            for (int d = 1; d < DIFF_DELAY; d++)
              dly_q[c][s][d] <= dly_q[c][s][d-1];
          end
        end
        if (vld_q[NUM_STAGES])
          data_q[c*DATAOUT_WIDTH +: DATAOUT_WIDTH] <=
            stg_q[c][NUM_STAGES][ACC_WIDTH-1 -: DATAOUT_WIDTH];
      end
    end
  end

  assign bus.data_o = data_q;
  assign bus.val_o  = val_q & en;
  assign bus.rate_o = rate_q;
endmodule

// File: tb/tb_cic_decim_mc.sv
// Bench for cic_decim_mc: random and directed stimulus against a sample-level CIC reference
// (integrate, decimate, N-th order binomial difference) with a due-time scoreboard for output timing.
module tb_cic_decim_mc;
  localparam int DIW  = 16;
  localparam int DOW  = 28;
  localparam int N    = 3;
  localparam int M    = 1;
  localparam int MAXR = 16;
  localparam int NCH  = 2;
  localparam int AW   = DIW + N * $clog2(MAXR * M);
  localparam int RW   = $clog2(MAXR + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cic_decim_mc_if #(.DATAIN_WIDTH(DIW), .DATAOUT_WIDTH(DOW), .MAXRATE(MAXR),
                    .NUM_CHANNELS(NCH)) bus ();

  cic_decim_mc #(.DATAIN_WIDTH(DIW), .DATAOUT_WIDTH(DOW), .NUM_STAGES(N),
                 .DIFF_DELAY(M), .MAXRATE(MAXR), .NUM_CHANNELS(NCH))
    dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus.slave));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state
  logic [AW-1:0]        m_int [NCH][N];
  logic [AW-1:0]        hist  [NCH][$];
  int                   m_rate, m_phase;
  int                   m_edges = 0;
  int                   due_q[$];
  logic [NCH*DOW-1:0]   dat_q[$];
  logic                 m_vq;
  logic [NCH*DOW-1:0]   m_dq;
  bit                   m_stb;

  logic                 obs_val, exp_val;
  logic [NCH*DOW-1:0]   obs_dat, exp_dat;
  int                   obs_rate, exp_rate;
  int                   dc_ref[$];

  function automatic int binom(int n, int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic int clamp_rate(int r);
    if (r == 0)    return 1;
    if (r > MAXR)  return MAXR;
    return r;
  endfunction

  function automatic int ch(int c);
    return int'($signed(obs_dat[c*DOW +: DOW]));
  endfunction

  function automatic logic [AW-1:0] comb_out(int c);
    logic [AW-1:0] acc;
    logic [AW-1:0] t;
    int n, idx;
    acc = '0;
    n = hist[c].size() - 1;
    for (int j = 0; j <= N; j++) begin
      idx = n - j * M;
      if (idx >= 0) begin
        t = AW'(binom(N, j)) * hist[c][idx];
        acc = (j % 2 == 1) ? acc - t : acc + t;
      end
    end
    return acc;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int s = 0; s < N; s++) m_int[c][s] = '0;
      hist[c].delete();
    end
    m_rate = MAXR; m_phase = 0;
    due_q.delete(); dat_q.delete();
    m_vq = 1'b0; m_dq = '0; m_stb = 1'b0;
  endfunction

  function automatic void model_edge(bit en, bit act, bit load, int rate, int d0, int d1);
    logic [AW-1:0]      old [NCH][N];
    logic [AW-1:0]      y;
    logic [NCH*DOW-1:0] pk;
    int r, ph;
    int d[NCH];
    m_stb = 1'b0;
    if (en) begin
      m_edges++;
      r  = load ? clamp_rate(rate) : m_rate;
      ph = load ? 0 : m_phase;
      if (act) begin
        d[0] = d0; d[1] = d1;
        m_stb = (ph == r - 1);
        old = m_int;
        for (int c = 0; c < NCH; c++) begin
          m_int[c][0] = old[c][0] + AW'(d[c]);
          for (int s = 1; s < N; s++) m_int[c][s] = old[c][s] + old[c][s-1];
        end
        if (m_stb) begin
          pk = '0;
          for (int c = 0; c < NCH; c++) begin
            hist[c].push_back(old[c][N-1]);
            y = comb_out(c);
            pk[c*DOW +: DOW] = y[AW-1 -: DOW];
          end
          due_q.push_back(m_edges + N + 1);
          dat_q.push_back(pk);
        end
        ph = m_stb ? 0 : ph + 1;
      end
      m_rate = r; m_phase = ph;
      if (due_q.size() > 0 && due_q[0] == m_edges) begin
        m_vq = 1'b1;
        m_dq = dat_q.pop_front();
        void'(due_q.pop_front());
      end else begin
        m_vq = 1'b0;
      end
    end
  endfunction

  task automatic step(input bit en, input bit act, input bit load, input int rate,
                      input int d0, input int d1);
    bus.en_i = en; bus.act_i = act; bus.rate_load_i = load;
    bus.rate_i = RW'(rate);
    bus.data_i = {DIW'(d1), DIW'(d0)};
    @(posedge clk);
    model_edge(en, act, load, rate, d0, d1);
    cyc++;
    @(negedge clk);
    obs_val = bus.val_o; obs_dat = bus.data_o; obs_rate = int'(bus.rate_o);
    exp_val = m_vq & en; exp_dat = m_dq; exp_rate = m_rate;
  endtask

  task automatic test_reset();
    model_reset();
    bus.en_i = 1'b0; bus.act_i = 1'b0; bus.rate_load_i = 1'b0;
    bus.rate_i = '0; bus.data_i = '0;
    rst_n = 1'b0;
    #12;
    tests++; if (bus.data_o !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", bus.data_o); end
    tests++; if (bus.val_o !== 1'b0) begin fails++; $display("FAIL reset_val: got %b want 0", bus.val_o); end
    tests++; if (int'(bus.rate_o) != MAXR) begin fails++; $display("FAIL reset_rate: got %0d want %0d", bus.rate_o, MAXR); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      tests++;
      if ({obs_val, obs_dat, obs_rate} !== {exp_val, exp_dat, exp_rate}) begin
        fails++;
        $display("FAIL reset_idle cyc %0d: dut val=%0b dat=%h rate=%0d, model val=%0b dat=%h rate=%0d", cyc, obs_val, obs_dat, obs_rate, exp_val, exp_dat, exp_rate);
      end
    end
  endtask

  task automatic test_dc(input bit again);
    int nval = 0;
    step(1, 0, 1, 4, 0, 0);
    for (int i = 0; i < 70; i++) begin
      step(1, (i % 2 == 0), 0, 0, 100, -100);
      tests++;
      if ({obs_val, obs_dat, obs_rate} !== {exp_val, exp_dat, exp_rate}) begin
        fails++;
        $display("FAIL dc_model cyc %0d: dut val=%0b dat=%h rate=%0d, model val=%0b dat=%h rate=%0d", cyc, obs_val, obs_dat, obs_rate, exp_val, exp_dat, exp_rate);
      end
      if (obs_val) begin
        if (nval >= 3) begin
          tests++;
          if (ch(0) != 6400 || ch(1) != -6400) begin
            fails++; $display("FAIL dc_settle out %0d: got %0d/%0d want 6400/-6400", nval, ch(0), ch(1));
          end
        end
        if (!again) begin
          dc_ref.push_back(ch(0)); dc_ref.push_back(ch(1));
        end else begin
          tests++;
          if (dc_ref.size() < 2 * nval + 2) begin
            fails++; $display("FAIL dc_repeat out %0d: extra output %0d/%0d", nval, ch(0), ch(1));
          end else if (ch(0) != dc_ref[2*nval] || ch(1) != dc_ref[2*nval+1]) begin
            fails++; $display("FAIL dc_repeat out %0d: got %0d/%0d want %0d/%0d", nval, ch(0), ch(1), dc_ref[2*nval], dc_ref[2*nval+1]);
          end
        end
        nval++;
      end
    end
    tests++; if (nval != 8) begin fails++; $display("FAIL dc_count: got %0d outputs want 8", nval); end
  endtask

  task automatic test_latency();
    int last_stb = -100;
    int last_val = -1;
    int d0, d1;
    step(1, 0, 1, 4, 0, 0);
    for (int i = 0; i < 48; i++) begin
      d0 = int'($urandom_range(65535)) - 32768;
      d1 = int'($urandom_range(65535)) - 32768;
      step(1, 1, 0, 0, d0, d1);
      tests++;
      if ({obs_val, obs_dat, obs_rate} !== {exp_val, exp_dat, exp_rate}) begin
        fails++;
        $display("FAIL lat_model cyc %0d: dut val=%0b dat=%h rate=%0d, model val=%0b dat=%h rate=%0d", cyc, obs_val, obs_dat, obs_rate, exp_val, exp_dat, exp_rate);
      end
      if (obs_val) begin
        tests++;
        if (cyc - last_stb != N + 1) begin fails++; $display("FAIL latency: got %0d cycles want %0d", cyc - last_stb, N + 1); end
        if (last_val >= 0) begin
          tests++;
          if (cyc - last_val != 4) begin fails++; $display("FAIL spacing: got %0d cycles want 4", cyc - last_val); end
        end
        last_val = cyc;
      end
      if (m_stb) last_stb = cyc;
    end
    step(1, 1, 1, 1, 7, -7);
    for (int i = 0; i < 30; i++) begin
      d0 = int'($urandom_range(65535)) - 32768;
      d1 = int'($urandom_range(65535)) - 32768;
      step(1, 1, 0, 0, d0, d1);
      tests++;
      if ({obs_val, obs_dat, obs_rate} !== {exp_val, exp_dat, exp_rate}) begin
        fails++;
        $display("FAIL rate1_model cyc %0d: dut val=%0b dat=%h rate=%0d, model val=%0b dat=%h rate=%0d", cyc, obs_val, obs_dat, obs_rate, exp_val, exp_dat, exp_rate);
      end
      if (i >= N) begin
        tests++; if (obs_val !== 1'b1) begin fails++; $display("FAIL rate1_cont cyc %0d: val_o got %b want 1", cyc, obs_val); end
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0, 0, 0);
      tests++;
      if ({obs_val, obs_dat, obs_rate} !== {exp_val, exp_dat, exp_rate}) begin
        fails++;
        $display("FAIL lat_drain cyc %0d: dut val=%0b dat=%h, model val=%0b dat=%h", cyc, obs_val, obs_dat, exp_val, exp_dat);
      end
    end
  endtask

  task automatic test_wrap();
    int nv;
    int seg_val [2];
    int seg_min [2];
    seg_val[0] = -32768; seg_val[1] = 32767;
    seg_min[0] = 5;      seg_min[1] = 6;
    step(1, 0, 1, 16, 0, 0);
    for (int g = 0; g < 2; g++) begin
      nv = 0;
      for (int i = 0; i < 200; i++) begin
        step(1, 1, 0, 0, seg_val[g], seg_val[g]);
        tests++;
        if ({obs_val, obs_dat, obs_rate} !== {exp_val, exp_dat, exp_rate}) begin
          fails++;
          $display("FAIL wrap_model cyc %0d: dut val=%0b dat=%h rate=%0d, model val=%0b dat=%h rate=%0d", cyc, obs_val, obs_dat, obs_rate, exp_val, exp_dat, exp_rate);
        end
        if (obs_val) begin
          nv++;
          if (nv >= seg_min[g]) begin
            tests++;
            if (ch(0) != seg_val[g] * 4096 || ch(1) != seg_val[g] * 4096) begin
              fails++; $display("FAIL wrap_settle seg %0d out %0d: got %0d/%0d want %0d", g, nv, ch(0), ch(1), seg_val[g] * 4096);
            end
          end
        end
      end
      tests++; if (nv < 11) begin fails++; $display("FAIL wrap_count seg %0d: got %0d outputs want >= 11", g, nv); end
    end
  endtask

  task automatic test_rate_change();
    int ld;
    int first_after = -1;
    int last0 = 0, last1 = 0;
    step(1, 0, 1, 4, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0, 100, -100);
    step(1, 1, 1, 8, 100, -100);
    ld = cyc;
    for (int i = 0; i < 120; i++) begin
      step(1, 1, 0, 0, 100, -100);
      tests++;
      if ({obs_val, obs_dat, obs_rate} !== {exp_val, exp_dat, exp_rate}) begin
        fails++;
        $display("FAIL rchg_model cyc %0d: dut val=%0b dat=%h rate=%0d, model val=%0b dat=%h rate=%0d", cyc, obs_val, obs_dat, obs_rate, exp_val, exp_dat, exp_rate);
      end
      if (obs_val) begin
        if (first_after < 0 && cyc >= ld + N + 1) first_after = cyc;
        last0 = ch(0); last1 = ch(1);
      end
    end
    tests++; if (first_after != ld + 8 + N) begin fails++; $display("FAIL rchg_first: val at +%0d cycles want +%0d", first_after - ld, 8 + N); end
    tests++; if (last0 != 51200 || last1 != -51200) begin fails++; $display("FAIL rchg_settle: got %0d/%0d want 51200/-51200", last0, last1); end
    step(1, 0, 1, 0, 0, 0);
    tests++; if (obs_rate != 1) begin fails++; $display("FAIL rate_clamp0: got %0d want 1", obs_rate); end
    step(1, 0, 1, 20, 0, 0);
    tests++; if (obs_rate != MAXR) begin fails++; $display("FAIL rate_clamp20: got %0d want %0d", obs_rate, MAXR); end
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 0, 0);
      tests++;
      if ({obs_val, obs_dat, obs_rate} !== {exp_val, exp_dat, exp_rate}) begin
        fails++;
        $display("FAIL rchg_drain cyc %0d: dut val=%0b dat=%h rate=%0d, model val=%0b dat=%h rate=%0d", cyc, obs_val, obs_dat, obs_rate, exp_val, exp_dat, exp_rate);
      end
    end
  endtask

  task automatic test_freeze();
    int sidx = -1;
    int seen = -1;
    logic [NCH*DOW-1:0] ev = '0;
    step(1, 0, 1, 4, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, 0, 50, -70);
      if (m_stb && i >= 8) begin
        sidx = cyc; ev = dat_q[$];
        break;
      end
    end
    tests++; if (sidx < 0) begin fails++; $display("FAIL freeze_setup: no strobe within 40 cycles"); end
    step(1, 1, 0, 0, 50, -70);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 50, -70);
      tests++; if (obs_val !== 1'b0) begin fails++; $display("FAIL freeze_val cyc %0d: got %b want 0", cyc, obs_val); end
      tests++;
      if ({obs_val, obs_dat, obs_rate} !== {exp_val, exp_dat, exp_rate}) begin
        fails++;
        $display("FAIL freeze_model cyc %0d: dut val=%0b dat=%h, model val=%0b dat=%h", cyc, obs_val, obs_dat, exp_val, exp_dat);
      end
    end
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0, 0, 0);
      tests++;
      if ({obs_val, obs_dat, obs_rate} !== {exp_val, exp_dat, exp_rate}) begin
        fails++;
        $display("FAIL thaw_model cyc %0d: dut val=%0b dat=%h, model val=%0b dat=%h", cyc, obs_val, obs_dat, exp_val, exp_dat);
      end
      if (obs_val && seen < 0) begin
        seen = cyc;
        tests++; if (obs_dat !== ev) begin fails++; $display("FAIL freeze_value: got %h want %h", obs_dat, ev); end
      end
    end
    tests++; if (seen != sidx + N + 1 + 5) begin fails++; $display("FAIL freeze_delay: val at +%0d want +%0d", seen - sidx, N + 6); end
  endtask

  task automatic test_async_reset();
    step(1, 0, 1, 4, 0, 0);
    for (int i = 0; i < 30; i++) step(1, 1, 0, 0, 123, -45);
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.data_o !== '0) begin fails++; $display("FAIL areset_data: got %h want 0", bus.data_o); end
    tests++; if (bus.val_o !== 1'b0) begin fails++; $display("FAIL areset_val: got %b want 0", bus.val_o); end
    tests++; if (int'(bus.rate_o) != MAXR) begin fails++; $display("FAIL areset_rate: got %0d want %0d", bus.rate_o, MAXR); end
    bus.en_i = 1'b0; bus.act_i = 1'b0; bus.rate_load_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      tests++;
      if ({obs_val, obs_dat, obs_rate} !== {exp_val, exp_dat, exp_rate}) begin
        fails++;
        $display("FAIL areset_idle cyc %0d: dut val=%0b dat=%h rate=%0d, model val=%0b dat=%h rate=%0d", cyc, obs_val, obs_dat, obs_rate, exp_val, exp_dat, exp_rate);
      end
    end
    test_dc(1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dc(1'b0);
    test_latency();
    test_wrap();
    test_rate_change();
    test_freeze();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
